// File: rtl/priority_arbiter.sv
// Eight-way resource arbiter: highest-index-first or round-robin selection,
// registered one-hot grant held until done, request drop or hold timeout.
module priority_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDW      = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           rr_mode,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [N-1:0]  ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;
  logic           timeout_q, timeout_d;
  logic [IDW-1:0] last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IDW-1:0] arb_start;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] win;
  logic           rel_norm;
  logic           rel_to;

  // Scan from start-1 downward with wrap; the nearest set bit overwrites farther ones.
  // A start of 0 gives the fixed order N-1 .. 0.
  always_comb begin
    win       = '0;
    arb_idx   = '0;
    arb_start = rr_mode ? last_q : '0;
    for (int k = int'(N); k >= 1; k--) begin
      arb_idx = IDW'((int'(arb_start) + int'(N) - k) % int'(N));
      if (req[arb_idx]) win = arb_idx;
    end
  end

  always_comb begin
    rel_norm = done | ~req[id_q];
    rel_to   = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = ONE_HOT0 << win;
          id_d    = win;
          valid_d = 1'b1;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        // Timeout is flagged only when it is the sole reason for release.
        if (rel_norm || rel_to) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          timeout_d = rel_to & ~rel_norm;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench for priority_arbiter: expected outputs are queued as each
// stimulus step is driven and checked one cycle later.
module tb_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rr_mode;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
    logic       v;
    logic       t;
  } out_t;

  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  priority_arbiter #(.N(8), .IDW(3), .MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_mode   (rr_mode),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [7:0] g, input logic [2:0] id, input logic v, input logic t);
    out_t e;
    e.g = g; e.id = id; e.v = v; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    out_t obs;
    out_t exp;
    obs = {gnt, gnt_id, gnt_valid, timeout};
    exp = exp_q.pop_front();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
             tag, obs.g, obs.id, obs.v, obs.t, exp.g, exp.id, exp.v, exp.t);
    end
  endtask

  // One clock step: queue expectation, advance past the edge, compare.
  task automatic tick(input string tag, input logic [7:0] g, input logic [2:0] id,
                      input logic v, input logic t);
    push_exp(g, id, v, t);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    logic [2:0] rr_ids [5];
    logic [7:0] one;
    rr_ids = '{3'd7, 3'd1, 3'd0, 3'd7, 3'd1};
    one    = 8'b0000_0001;

    rst_n = 1'b0; req = 8'hFF; rr_mode = 1'b0; done = 1'b0;
    #2;
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    check_out("reset_async");
    tick("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);
    tick("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b1; req = 8'h00;
    for (int i = 0; i < 5; i++) tick("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0);

    // Fixed priority, done release and immediate re-grant after one gap cycle
    req = 8'b0010_0110;
    tick("fix_grant", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    tick("fix_done_rel", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b0;
    tick("fix_regrant", 8'b0010_0000, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick("fix_req_drop", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b1;
    tick("idle_done", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b0;
    tick("idle_after_done", 8'h00, 3'd5, 1'b0, 1'b0);

    // Async reset between edges while id 6 owns the resource
    req = 8'b0100_0000;
    tick("pre_rst_grant", 8'b0100_0000, 3'd6, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 3'd0, 1'b0, 1'b0);
    check_out("mid_rst_async");
    tick("mid_rst_hold", 8'h00, 3'd0, 1'b0, 1'b0);

    // Round-robin restarts at 7 after reset
    rst_n = 1'b1; rr_mode = 1'b1; req = 8'b1000_0011;
    for (int i = 0; i < 5; i++) begin
      tick("rr_grant", one << rr_ids[i], rr_ids[i], 1'b1, 1'b0);
      done = 1'b1;
      tick("rr_gap", 8'h00, rr_ids[i], 1'b0, 1'b0);
      done = 1'b0;
    end
    req = 8'h00; rr_mode = 1'b0;
    tick("rr_idle", 8'h00, 3'd1, 1'b0, 1'b0);

    // Hold timeout: exactly 16 grant cycles, one timeout pulse, then re-grant
    req = 8'b0000_1000;
    for (int i = 0; i < 16; i++) tick("to_hold", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
    tick("to_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    tick("to_regrant", 8'b0000_1000, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick("to_drop", 8'h00, 3'd3, 1'b0, 1'b0);

    // Request drop coinciding with the last hold cycle: no timeout pulse
    req = 8'b0001_0000;
    for (int i = 0; i < 16; i++) tick("co_hold", 8'b0001_0000, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    tick("co_release", 8'h00, 3'd4, 1'b0, 1'b0);
    tick("co_after", 8'h00, 3'd4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
